// File: rtl/fp32_mult_result_buffer.sv
// Result FIFO behind multiplier32FP: captures product+flags on done_i and serves them over valid/ready.
// Optional NaN result counter enabled by defining RESULT_NAN_STATS_EN.
module fp32_mult_result_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done_i,
  input  logic [31:0]              product_i,
  input  logic                     nan_i,
  input  logic                     infinit_i,
  input  logic                     overflow_i,
  input  logic                     underflow_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [31:0]              product_o,
  output logic [3:0]               flags_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic [3:0]               sticky_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  input  logic                     clear_i,
  output logic [15:0]              nan_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [35:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [3:0]        sticky_q, sticky_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [3:0]  in_flags;
  logic [35:0] entry;
  logic        full, pop, push, drop;

  assign in_flags = {nan_i, infinit_i, overflow_i, underflow_i};
  assign entry    = {in_flags, product_i};

  assign full = (count_q == CntW'(DEPTH));
  assign pop  = (count_q != '0) && ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = done_i && (!full || pop);
  assign drop = done_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear applies first so a same-cycle accept or drop lands on the cleared value.
  always_comb begin
    sticky_d = clear_i ? 4'b0 : sticky_q;
    drop_d   = clear_i ? '0 : drop_q;
    if (push) sticky_d = sticky_d | in_flags;
    if (drop && (drop_d != '1)) drop_d = drop_d + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  assign valid_o    = (count_q != '0);
  assign product_o  = mem_q[rd_ptr_q][31:0];
  assign flags_o    = mem_q[rd_ptr_q][35:32];
  assign count_o    = count_q;
  assign full_o     = full;
  assign sticky_o   = sticky_q;
  assign drop_cnt_o = drop_q;

`ifdef RESULT_NAN_STATS_EN
  logic [15:0] nan_cnt_q, nan_cnt_d;

  always_comb begin
    nan_cnt_d = clear_i ? 16'h0 : nan_cnt_q;
    if (push && nan_i && (nan_cnt_d != 16'hFFFF)) nan_cnt_d = nan_cnt_d + 16'h1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) nan_cnt_q <= 16'h0;
    else        nan_cnt_q <= nan_cnt_d;
  end

  assign nan_cnt_o = nan_cnt_q;
`else
  assign nan_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_fp32_mult_result_buffer.sv
// Scoreboard bench for fp32_mult_result_buffer: a queue model predicts accepts/drops, a negedge
// monitor pops and compares the head whenever a handshake occurs.
module tb_fp32_mult_result_buffer;
  localparam int DEPTH    = 4;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done_i = 1'b0;
  logic [31:0] product_i = '0;
  logic        nan_i = 1'b0, infinit_i = 1'b0, overflow_i = 1'b0, underflow_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        valid_o, full_o;
  logic [31:0] product_o;
  logic [3:0]  flags_o, sticky_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [DROP_W-1:0]      drop_cnt_o;
  logic [15:0]            nan_cnt_o;

  always #5 clk = ~clk;

  fp32_mult_result_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .done_i(done_i), .product_i(product_i), .nan_i(nan_i),
    .infinit_i(infinit_i), .overflow_i(overflow_i), .underflow_i(underflow_i),
    .valid_o(valid_o), .ready_i(ready_i), .product_o(product_o), .flags_o(flags_o),
    .count_o(count_o), .full_o(full_o), .sticky_o(sticky_o), .drop_cnt_o(drop_cnt_o),
    .clear_i(clear_i), .nan_cnt_o(nan_cnt_o)
  );

  // Model state: queue of {flags, product} entries plus status values.
  logic [35:0] exp_q[$];
  logic [3:0]  exp_sticky = '0;
  int          exp_drop = 0;
  int          exp_nan = 0;
  bit          mon_popped = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare against model, pop on handshake.
  always @(negedge clk) begin
    mon_popped = 1'b0;
    if (rst_n) begin
      check("valid", 64'(valid_o), 64'(exp_q.size() != 0));
      check("count", 64'(count_o), 64'(exp_q.size()));
      check("full", 64'(full_o), 64'(exp_q.size() == DEPTH));
      check("sticky", 64'(sticky_o), 64'(exp_sticky));
      check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
      check("nan_cnt", 64'(nan_cnt_o), 64'(exp_nan));
      if (exp_q.size() != 0) begin
        check("head_product", 64'(product_o), 64'(exp_q[0][31:0]));
        check("head_flags", 64'(flags_o), 64'(exp_q[0][35:32]));
        if (ready_i) begin
          void'(exp_q.pop_front());
          mon_popped = 1'b1;
        end
      end
    end
  end

  // Predict the effect of this cycle's inputs at the coming edge (monitor already handled the pop).
  task automatic predict();
    int pre;
    logic [3:0] f;
    if (!rst_n) begin
      exp_q.delete();
      exp_sticky = '0;
      exp_drop   = 0;
      exp_nan    = 0;
    end else begin
      pre = exp_q.size() + (mon_popped ? 1 : 0);
      f = {nan_i, infinit_i, overflow_i, underflow_i};
      if (clear_i) begin
        exp_sticky = '0;
        exp_drop   = 0;
`ifdef RESULT_NAN_STATS_EN
        exp_nan    = 0;
`endif
      end
      if (done_i) begin
        if (pre < DEPTH || mon_popped) begin
          exp_q.push_back({f, product_i});
          exp_sticky = exp_sticky | f;
`ifdef RESULT_NAN_STATS_EN
          if (f[3] && exp_nan < 65535) exp_nan++;
`endif
        end else if (exp_drop < DROP_MAX) begin
          exp_drop++;
        end
      end
    end
  endtask

  task automatic cycle(input logic d, input logic [31:0] p, input logic [3:0] f,
                       input logic r, input logic c, input logic rn);
    @(posedge clk);
    #1;
    done_i = d; product_i = p; {nan_i, infinit_i, overflow_i, underflow_i} = f;
    ready_i = r; clear_i = c; rst_n = rn;
    @(negedge clk);
    #1;
    predict();
  endtask

  initial begin
    logic [3:0] rf;
    cycle(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 4'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Single entry through with ready high.
    cycle(1'b1, 32'h4120_0000, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Overfill by one, then drain in order.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h3F80_0000 + 32'(i) * 32'h0080_0000 - ((i > 0) ? 32'h0000_0000 : 32'h0),
            4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Push+pop while full, three fills to wrap the pointers.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h1000 * k + 32'(i), 4'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5000 + 32'(i), 4'h0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);
    end

    // Sticky flags and clear with a same-cycle accept.
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 32'h7FC0_0000, 4'h8, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h7F80_0000, 4'h6, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0001, 4'h1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);

    // NaN stats: 3 accepted NaNs (incl. fill), then a dropped NaN; clear with a drop.
    cycle(1'b0, '0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h7FC0_0000 + 32'(i), (i < 3) ? 4'h8 : 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h7FC0_1111, 4'h8, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h7FC0_2222, 4'h8, 1'b0, 1'b1, 1'b1);

    // Saturate the drop counter, then reset with entries queued and done_i high.
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'(i), 4'h2, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hCAFE_0000, 4'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with stall bursts.
    for (int i = 0; i < 3000; i++) begin
      rf = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) rf = 4'h0;
      cycle(1'($urandom_range(0, 1)), $urandom, rf,
            ((i / 40) % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 60) == 0), 1'b1);
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 4'h0, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
